regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised successor to the single-write/two-read regfile used by the processor top level.
//  Adds N read ports, configurable width/depth, and a per-register pending (scoreboard) bit set at
//  issue of a multicycle op (mult/div, lw) and cleared at its writeback, so the pipeline can stall.
//  Sits between the processor core and writeback; all storage is internal flops, no RAM macro.
// PARAMETERS
//  WIDTH    32  data bits per register
//  DEPTH    32  number of registers; need not be a power of two
//  NUM_RD   2   number of independent read ports (1..8)
//  AW       5   register address width; must satisfy 2**AW >= DEPTH
// PORTS
//  clock             in   1             single clock, all state updates on rising edge
//  reset             in   1             asynchronous, active-low; clears all state
//  ctrl_writeEnable  in   1             write strobe for writeback port
//  ctrl_writeReg     in   AW            writeback register index
//  data_writeReg     in   WIDTH         writeback data
//  ctrl_readReg      in   NUM_RD*AW     read indices, port i at [i*AW +: AW]
//  data_readReg      out  NUM_RD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
//  busy_set          in   1             mark busy_setReg pending (multicycle op issued)
//  busy_setReg       in   AW            register to mark pending
//  busy_rd           out  NUM_RD        pending status of each read port's register
//  busy_count        out  $clog2(DEPTH+1)  number of registers currently pending
// BEHAVIOUR
//  - Reset (reset==0, async): all registers <= 0, all pending bits <= 0; data_readReg = 0,
//    busy_rd = 0, busy_count = 0 while asserted and immediately after release.
//  - Write: at rising edge, if ctrl_writeEnable && ctrl_writeReg!=0 && ctrl_writeReg<DEPTH,
//    reg[ctrl_writeReg] <= data_writeReg. Writes to reg 0 or out-of-range index are dropped.
//  - Read: combinational, zero latency. Index 0 or index >= DEPTH returns 0. Ports independent;
//    any number of ports may read the same register.
//  - Pending bit p[r]: cleared at edge by a qualifying write to r; set at edge by busy_set with
//    busy_setReg==r, r!=0, r<DEPTH. Same-edge set and clear on same r: set wins (new op issued
//    after the older one retires). p[0] is constant 0.
//  - busy_rd[i] = p[ctrl_readReg_i] (0 for index 0/out-of-range), subject to bypass below.
//  - busy_count = popcount of p, registered; updated the cycle after the set/clear edge,
//    never exceeds DEPTH-1.
//  - Reset mid-operation: pending ops are forgotten; core must also flush its multicycle units.
// CONFIGURATION
//  RF_BYPASS_EN defined: write-through forwarding. When ctrl_writeEnable && ctrl_writeReg==
//   ctrl_readReg_i (nonzero, in range), data_readReg_i = data_writeReg in the same cycle and
//   busy_rd[i] = 0 unless busy_set targets the same register in that cycle.
//  RF_BYPASS_EN undefined: reads return the stored value; new data visible one cycle after the
//   write edge; busy_rd[i] reflects p only (drops the cycle after writeback).
//  Timing-critical builds leave it undefined and clock regfile on the inverted clock instead.
// STRUCTURE
//  Shared package rf_pkg: RF_WIDTH/RF_DEPTH/RF_AW defaults, localparam ZERO_REG = 0,
//   function popcount used for busy_count.
//  One sub-module: rf_read_port (index decode, range check, zero-reg mux, optional bypass),
//   instantiated NUM_RD times via generate. Storage and scoreboard remain in the top module.
// TESTING
//  1 reset low mid-run after writing r5=0xDEADBEEF -> all read ports 0, busy_count 0, instantly.
//  2 write r0=0x1234 then read r0 on every port -> 0; write r31=0xA5A5A5A5 -> port1 reads it
//    next cycle (bypass off) / same cycle (RF_BYPASS_EN).
//  3 DEPTH=24: write r30=0xFFFF -> dropped, read r30 -> 0, no other register modified.
//  4 busy_set r7; next cycle read r7 -> busy_rd=1, busy_count=1; write r7=0x77 -> busy_rd=0 after
//    edge (same cycle with bypass), data 0x77, busy_count=0.
//  5 same edge: busy_set r9 and write r9=0x99 -> r9 holds 0x99, p[9]=1, busy_count=1.
//  6 NUM_RD=4, all ports read r3 while r3 written 0x3 -> all four ports return identical values.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg : shared definitions for the multi-port register file (regfile_mp).
//   RF_WIDTH / RF_DEPTH / RF_AW / RF_NUM_RD : default geometry
//   ZERO_REG     : index of the hard-wired zero register
//   RF_MAX_DEPTH : largest DEPTH the popcount helper can count (2**8)
//   popcount()   : number of set bits, used for the pending-register count
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_WIDTH     = 32;
    localparam int RF_DEPTH     = 32;
    localparam int RF_AW        = 5;
    localparam int RF_NUM_RD    = 2;
    localparam int ZERO_REG     = 0;
    localparam int RF_MAX_DEPTH = 256;

    // Count the set bits of a (zero-extended) pending vector.
    function automatic int unsigned popcount(input logic [RF_MAX_DEPTH-1:0] vec);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < RF_MAX_DEPTH; i++) begin
            cnt = cnt + {31'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if : bus between the processor core / writeback and regfile_mp.
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : writeback port
//   ctrl_readReg  (NUM_RD*AW)    : read indices, port i at [i*AW +: AW]
//   data_readReg  (NUM_RD*WIDTH) : read data,    port i at [i*WIDTH +: WIDTH]
//   busy_set/busy_setReg         : mark a register pending (multicycle issue)
//   busy_rd (NUM_RD)             : pending status seen by each read port
//   busy_count                   : number of pending registers (registered)
// Modports: master = core side, slave = register file.
// ---------------------------------------------------------------------------
interface regfile_mp_if
    import rf_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int AW     = RF_AW
) ();

    localparam int CW = $clog2(DEPTH + 1);

    logic                    ctrl_writeEnable;
    logic [AW-1:0]           ctrl_writeReg;
    logic [WIDTH-1:0]        data_writeReg;
    logic [NUM_RD*AW-1:0]    ctrl_readReg;
    logic [NUM_RD*WIDTH-1:0] data_readReg;
    logic                    busy_set;
    logic [AW-1:0]           busy_setReg;
    logic [NUM_RD-1:0]       busy_rd;
    logic [CW-1:0]           busy_count;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
        output busy_set, busy_setReg,
        input  data_readReg, busy_rd, busy_count
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
        input  busy_set, busy_setReg,
        output data_readReg, busy_rd, busy_count
    );

endinterface

// File: rtl/regfile_mp_read_port.sv
// ---------------------------------------------------------------------------
// rf_read_port : one combinational read port of regfile_mp.
//   active  : high when the register file is out of reset; forces zeros otherwise
//   idx     : register index; 0 or >= DEPTH reads as 0 / not pending
//   regs    : stored register values, pend : pending bits
//   rdata   : read data, rbusy : pending status of the indexed register
// Optional macro RF_BYPASS_EN adds write-through forwarding inputs
// (wr_en/wr_reg/wr_data) and the same-cycle issue inputs (set_en/set_reg).
// ---------------------------------------------------------------------------
module rf_read_port
    import rf_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = RF_AW
) (
`ifdef RF_BYPASS_EN
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_reg,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             set_en,
    input  logic [AW-1:0]    set_reg,
`endif
    input  logic             active,
    input  logic [AW-1:0]    idx,
    input  logic [WIDTH-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0] pend,
    output logic [WIDTH-1:0] rdata,
    output logic             rbusy
);

    logic             valid_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_pend_s;

    // Index is usable only if it is not the zero register and lies inside the file.
    always_comb begin
        valid_s = (idx != AW'(ZERO_REG)) && (32'(idx) < 32'(DEPTH));
    end

    // AND-OR mux over the storage; DEPTH need not be a power of two.
    always_comb begin
        sel_data_s = '0;
        sel_pend_s = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            sel_data_s = sel_data_s | ({WIDTH{idx == AW'(r)}} & regs[r]);
            sel_pend_s = sel_pend_s | ((idx == AW'(r)) & pend[r]);
        end
    end

`ifdef RF_BYPASS_EN
    logic fwd_s;
    logic set_same_s;

    // Forward the writeback data when it targets this port's register this cycle.
    always_comb begin
        fwd_s      = wr_en && valid_s && (wr_reg == idx);
        set_same_s = set_en && (set_reg == idx);
    end

    // Output select: forwarded write clears busy unless a new op issues to the same register.
    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (!active || !valid_s) begin
            rdata = '0;
            rbusy = 1'b0;
        end else if (fwd_s) begin
            rdata = wr_data;
            rbusy = set_same_s;
        end else begin
            rdata = sel_data_s;
            rbusy = sel_pend_s;
        end
    end
`else
    // Output select: stored value and pending bit only.
    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (!active || !valid_s) begin
            rdata = '0;
            rbusy = 1'b0;
        end else begin
            rdata = sel_data_s;
            rbusy = sel_pend_s;
        end
    end
`endif

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp : parametrised multi-read-port register file with a per-register
// pending (scoreboard) bit for multicycle ops.
//   clock : rising-edge clock
//   reset : asynchronous, active-low; clears registers, pending bits, count
//   bus   : regfile_mp_if.slave (writeback, read ports, busy set, status)
// Parameters WIDTH, DEPTH (<= 256, any value), NUM_RD (1..8), AW (2**AW >= DEPTH).
// Register 0 reads as zero and is never pending. A write and a busy_set to the
// same register on the same edge leave it pending (the newer op wins).
// Optional macro RF_BYPASS_EN: write-through forwarding to the read ports.
// ---------------------------------------------------------------------------
module regfile_mp
    import rf_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int AW     = RF_AW
) (
    input  logic         clock,
    input  logic         reset,
    regfile_mp_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]        regs_q [DEPTH];
    logic [WIDTH-1:0]        regs_d [DEPTH];
    logic [DEPTH-1:0]        pend_q;
    logic [DEPTH-1:0]        pend_d;
    logic [CW-1:0]           busy_count_q;
    logic [CW-1:0]           busy_count_d;
    logic                    wr_ok_s;
    logic                    set_ok_s;
    logic [RF_MAX_DEPTH-1:0] pend_ext_s;

    // Qualify writeback and issue: register 0 and out-of-range indices are ignored.
    always_comb begin
        wr_ok_s  = bus.ctrl_writeEnable
                   && (bus.ctrl_writeReg != AW'(ZERO_REG))
                   && (32'(bus.ctrl_writeReg) < 32'(DEPTH));
        set_ok_s = bus.busy_set
                   && (bus.busy_setReg != AW'(ZERO_REG))
                   && (32'(bus.busy_setReg) < 32'(DEPTH));
    end

    // Next register contents.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
            if (wr_ok_s && (bus.ctrl_writeReg == AW'(r))) begin
                regs_d[r] = bus.data_writeReg;
            end else begin
                regs_d[r] = regs_q[r];
            end
        end
    end

    // Next pending bits: issue has priority over retirement on the same edge.
    always_comb begin
        pend_d = pend_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (r == ZERO_REG) begin
                pend_d[r] = 1'b0;
            end else if (set_ok_s && (bus.busy_setReg == AW'(r))) begin
                pend_d[r] = 1'b1;
            end else if (wr_ok_s && (bus.ctrl_writeReg == AW'(r))) begin
                pend_d[r] = 1'b0;
            end else begin
                pend_d[r] = pend_q[r];
            end
        end
    end

    // Pending count lags the pending bits by one cycle (counted from the registered bits).
    always_comb begin
        pend_ext_s              = '0;
        pend_ext_s[DEPTH-1:0]   = pend_q;
        busy_count_d            = CW'(popcount(pend_ext_s));
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            pend_q       <= '0;
            busy_count_q <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pend_q       <= pend_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign bus.busy_count = busy_count_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_rd (
`ifdef RF_BYPASS_EN
            .wr_en   (bus.ctrl_writeEnable),
            .wr_reg  (bus.ctrl_writeReg),
            .wr_data (bus.data_writeReg),
            .set_en  (bus.busy_set),
            .set_reg (bus.busy_setReg),
`endif
            .active  (reset),
            .idx     (bus.ctrl_readReg[i*AW +: AW]),
            .regs    (regs_q),
            .pend    (pend_q),
            .rdata   (bus.data_readReg[i*WIDTH +: WIDTH]),
            .rbusy   (bus.busy_rd[i])
        );
    end

endmodule
